// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern controller:
//   - LED_W          : number of LED outputs (active-low, 0 = lit)
//   - mode_e         : pattern mode encoding reported on the mode output
//   - dir_e          : travel direction of the lit bit in BOUNCE mode
//   - *_ENTRY        : LED pattern loaded when a mode is entered
//   - SYNC_STAGES    : depth of the key input synchronizer
//   - next_mode()    : mode sequence SHIFT -> BOUNCE -> BLINK -> COUNT -> SHIFT
//   - entry_pattern(): entry LED pattern of a mode
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int LED_W       = 6;
  localparam int SYNC_STAGES = 2;

  // Level of key_n when the button is not pressed.
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    BOUNCE = 2'd1,
    BLINK  = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] SHIFT_ENTRY  = 6'b111110;
  localparam logic [LED_W-1:0] BOUNCE_ENTRY = 6'b111110;
  localparam logic [LED_W-1:0] BLINK_ENTRY  = 6'b000000;
  // COUNT starts at binary 0, shown inverted on the active-low LEDs.
  localparam logic [LED_W-1:0] COUNT_ENTRY  = 6'b111111;

  // Modes wrap naturally in the 2-bit encoding (COUNT + 1 = SHIFT).
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

  function automatic logic [LED_W-1:0] entry_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    case (m)
      SHIFT:   p = SHIFT_ENTRY;
      BOUNCE:  p = BOUNCE_ENTRY;
      BLINK:   p = BLINK_ENTRY;
      COUNT:   p = COUNT_ENTRY;
      default: p = SHIFT_ENTRY;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes the asynchronous active-low button, optionally debounces it,
// and emits a single-cycle pulse on each accepted press (filtered 1->0 edge).
//
// Configuration macro: LED_DEBOUNCE_EN
//   defined   : the filtered key follows the synchronized key only after the
//               two have differed for DEB_CYC consecutive cycles.
//   undefined : the filtered key is the synchronized key; DEB_CYC is unused.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   key_n_i  in   asynchronous button level, 0 = pressed
//   press_o  out  1-cycle press pulse
// -----------------------------------------------------------------------------
module key_debounce
  import led_pkg::*;
#(
  parameter int unsigned DEB_CYC = 540_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   armed_q;
  logic                   key_prev_q;
  logic                   key_filt;
  logic                   key_sync;

  assign key_sync = sync_q[SYNC_STAGES-1];

  // vld_q fills with ones as real samples replace the reset value in the
  // synchronizer. Presses are accepted only once a released level has been
  // observed from the pin, so a key still held through reset release cannot
  // be mistaken for a new press.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= {SYNC_STAGES{KEY_RELEASED}};
      vld_q      <= '0;
      armed_q    <= 1'b0;
      key_prev_q <= KEY_RELEASED;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], key_n_i};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      armed_q    <= armed_q | (vld_q[SYNC_STAGES-1] & (key_sync == KEY_RELEASED));
      key_prev_q <= key_filt;
    end
  end

`ifdef LED_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [DEB_W-1:0] deb_cnt_q;
  logic             key_filt_q;

  // The counter runs only while the synchronized key disagrees with the
  // filtered key; any agreement restarts the stability window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_cnt_q  <= '0;
      key_filt_q <= KEY_RELEASED;
    end else if (key_sync != key_filt_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
        key_filt_q <= key_sync;
        deb_cnt_q  <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  assign key_filt = key_filt_q;
`else
  assign key_filt = key_sync;

  // DEB_CYC has no role without the debounce filter.
  logic unused_deb_cyc;
  assign unused_deb_cyc = (DEB_CYC == 0);
`endif

  // Falling edge of the filtered key only; holding or releasing never pulses.
  assign press_o = armed_q & key_prev_q & ~key_filt;

endmodule

// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
// Button-driven LED pattern generator with four modes (SHIFT, BOUNCE, BLINK,
// COUNT). A free-running tick counter paces the pattern; each button press
// advances the mode, restarts the tick period and loads the mode's entry
// pattern. A press arriving with a tick takes priority and the tick is lost.
//
// Configuration macro: LED_DEBOUNCE_EN (enables the debounce filter inside
// key_debounce; without it the key is only synchronized).
//
// Parameters
//   TICK_CYC   clock cycles per pattern step
//   DEB_CYC    cycles the key must be stable before it is accepted
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   key_n      in   asynchronous button, 0 = pressed
//   led        out  registered active-low LEDs, 0 = lit
//   mode       out  registered mode encoding (mode_e)
// -----------------------------------------------------------------------------
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_CYC = 3_500_000,
  parameter int unsigned DEB_CYC  = 540_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_n,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int unsigned TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic              press;
  logic              tick;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  mode_e             mode_q,     mode_d;
  logic [LED_W-1:0]  led_q,      led_d;
  dir_e              dir_q,      dir_d;
  logic [LED_W-1:0]  count_q,    count_d;

  key_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_key_debounce (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .key_n_i (key_n),
    .press_o (press)
  );

  assign tick = (tick_cnt_q == TICK_W'(TICK_CYC - 1));

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    mode_d     = mode_q;
    led_d      = led_q;
    dir_d      = dir_q;
    count_d    = count_q;

    if (press) begin
      mode_d     = next_mode(mode_q);
      led_d      = entry_pattern(mode_d);
      dir_d      = DIR_UP;
      count_d    = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      case (mode_q)
        SHIFT: begin
          led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        end
        BOUNCE: begin
          // The lit (0) bit moves one place; direction turns on the step that
          // reaches an end, so the end position is shown exactly once.
          if (dir_q == DIR_UP) begin
            led_d = {led_q[LED_W-2:0], 1'b1};
            if (!led_d[LED_W-1]) dir_d = DIR_DOWN;
          end else begin
            led_d = {1'b1, led_q[LED_W-1:1]};
            if (!led_d[0]) dir_d = DIR_UP;
          end
        end
        BLINK: begin
          led_d = ~led_q;
        end
        COUNT: begin
          count_d = count_q + LED_W'(1);
          led_d   = ~count_d;
        end
        default: begin
          led_d = led_q;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
      mode_q     <= SHIFT;
      led_q      <= SHIFT_ENTRY;
      dir_q      <= DIR_UP;
      count_q    <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
// Directed bench for led_mode_ctrl with TICK_CYC=4, DEB_CYC=3. A table of
// {action, cycles, expected led, expected mode} records walks the main mode
// sequence; hand-written sequences cover key hold, glitch and async reset.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;
  import led_pkg::*;

  localparam int TICK = 4;
  localparam int DEB  = 3;

`ifdef LED_DEBOUNCE_EN
  // key low -> sync (2) -> 3 stable cycles -> press pulse -> register
  localparam int    PL          = 6;
  localparam int    GLITCH_CHG  = 0;
  localparam mode_e GLITCH_MODE = BOUNCE;
`else
  // key low -> sync (2) -> press pulse -> register
  localparam int    PL          = 3;
  localparam int    GLITCH_CHG  = 1;
  localparam mode_e GLITCH_MODE = BLINK;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             key_n;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;

  int n_cmp  = 0;
  int n_fail = 0;

  led_mode_ctrl #(
    .TICK_CYC (TICK),
    .DEB_CYC  (DEB)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .key_n     (key_n),
    .led       (led),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  typedef enum {OP_WAIT, OP_PRESS} op_e;
  typedef struct {
    op_e              op;
    int               cyc;
    logic [LED_W-1:0] led;
    mode_e            mode;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the key low until the mode changes (bounded), release it, and check
  // the press latency plus the state loaded by the press.
  task automatic do_press(input string name, input logic [LED_W-1:0] exp_led,
                          input mode_e exp_mode);
    logic [1:0] m0;
    int         lat;
    m0    = mode;
    lat   = -1;
    key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mode !== m0) begin
        lat = i;
        break;
      end
    end
    key_n = 1'b1;
    check({name, " latency"}, lat, PL);
    check({name, " led"}, led, exp_led);
    check({name, " mode"}, mode, exp_mode);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] prev;
    int         chg;

    // Main sequence; times are negedges after the previous record.
    vecs[0]  = '{OP_WAIT,  3,        6'b111110, SHIFT};
    vecs[1]  = '{OP_WAIT,  1,        6'b111101, SHIFT};
    vecs[2]  = '{OP_WAIT,  4,        6'b111011, SHIFT};
    vecs[3]  = '{OP_WAIT,  4,        6'b110111, SHIFT};
    vecs[4]  = '{OP_WAIT,  4,        6'b101111, SHIFT};
    vecs[5]  = '{OP_WAIT,  4,        6'b011111, SHIFT};
    vecs[6]  = '{OP_WAIT,  4,        6'b111110, SHIFT};
    vecs[7]  = '{OP_PRESS, 2,        6'b111110, BOUNCE};
    vecs[8]  = '{OP_WAIT,  4,        6'b111101, BOUNCE};
    vecs[9]  = '{OP_WAIT,  4,        6'b111011, BOUNCE};
    vecs[10] = '{OP_WAIT,  4,        6'b110111, BOUNCE};
    vecs[11] = '{OP_WAIT,  4,        6'b101111, BOUNCE};
    vecs[12] = '{OP_WAIT,  4,        6'b011111, BOUNCE};
    vecs[13] = '{OP_WAIT,  4,        6'b101111, BOUNCE};
    vecs[14] = '{OP_WAIT,  4,        6'b110111, BOUNCE};
    vecs[15] = '{OP_WAIT,  4,        6'b111011, BOUNCE};
    vecs[16] = '{OP_WAIT,  4,        6'b111101, BOUNCE};
    vecs[17] = '{OP_WAIT,  4,        6'b111110, BOUNCE};
    vecs[18] = '{OP_WAIT,  4,        6'b111101, BOUNCE};
    vecs[19] = '{OP_PRESS, 6,        6'b000000, BLINK};
    vecs[20] = '{OP_WAIT,  3,        6'b000000, BLINK};
    vecs[21] = '{OP_WAIT,  1,        6'b111111, BLINK};
    vecs[22] = '{OP_WAIT,  4,        6'b000000, BLINK};
    // Press pulse lands on the 4th BLINK tick: the tick must be discarded.
    vecs[23] = '{OP_PRESS, 8 - PL,   6'b111111, COUNT};
    vecs[24] = '{OP_WAIT,  3,        6'b111111, COUNT};
    vecs[25] = '{OP_WAIT,  1,        6'b111110, COUNT};
    vecs[26] = '{OP_WAIT,  4,        6'b111101, COUNT};
    vecs[27] = '{OP_WAIT,  4 * 60,   6'b000001, COUNT};
    vecs[28] = '{OP_WAIT,  4,        6'b000000, COUNT};
    vecs[29] = '{OP_WAIT,  4,        6'b111111, COUNT};
    vecs[30] = '{OP_PRESS, 6,        6'b111110, SHIFT};
    vecs[31] = '{OP_WAIT,  4,        6'b111101, SHIFT};

    // Reset state with the clock running.
    rst_n = 1'b0;
    key_n = 1'b1;
    step(2);
    check("reset led", led, SHIFT_ENTRY);
    check("reset mode", mode, SHIFT);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].cyc);
      if (vecs[i].op == OP_PRESS) begin
        do_press($sformatf("v%0d press", i), vecs[i].led, vecs[i].mode);
      end else begin
        check($sformatf("v%0d led", i), led, vecs[i].led);
        check($sformatf("v%0d mode", i), mode, vecs[i].mode);
      end
    end

    // Key held low for 10 cycles: exactly one mode change.
    step(6);
    key_n = 1'b0;
    prev  = mode;
    chg   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 10) key_n = 1'b1;
      if (mode !== prev) begin
        chg++;
        prev = mode;
      end
    end
    check("hold event count", chg, 1);
    check("hold mode", mode, BOUNCE);

    // Async reset in BOUNCE while a press is still being filtered.
    step(10);
    key_n = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("async reset led", led, SHIFT_ENTRY);
    check("async reset mode", mode, SHIFT);
    step(3);
    rst_n = 1'b1;
    prev  = mode;
    chg   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) check("post-reset first step", led, 6'b111101);
      if (mode !== prev) begin
        chg++;
        prev = mode;
      end
    end
    check("held key after reset events", chg, 0);
    check("held key after reset mode", mode, SHIFT);
    key_n = 1'b1;
    step(10);
    do_press("re-press", BOUNCE_ENTRY, BOUNCE);

    // Two-cycle glitch: rejected only when the debounce filter is built in.
    step(10);
    key_n = 1'b0;
    step(2);
    key_n = 1'b1;
    prev  = mode;
    chg   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mode !== prev) begin
        chg++;
        prev = mode;
      end
    end
    check("glitch event count", chg, GLITCH_CHG);
    check("glitch mode", mode, GLITCH_MODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter TICK_CYC, default 3_500_000, is the number of sys_clk cycles per pattern step (about 130 ms at 27 MHz).
REQ-002 Parameter DEB_CYC, default 540_000, is the number of cycles key_n must be stable before it is accepted (20 ms at 27 MHz).
REQ-003 Port sys_clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-004 Port sys_rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port key_n, input, 1 bit, is the asynchronous user button; 0 means pressed.
REQ-006 Port led, output, 6 bits, registered, drives active-low LEDs; 0 means lit.
REQ-007 Port mode, output, 2 bits, registered, reports the current mode encoding.

Function
REQ-010 Tick counter SHALL count 0..TICK_CYC-1 and wrap; tick is a 1-cycle pulse when count==TICK_CYC-1.
REQ-011 key_n SHALL pass a 2-flop synchronizer; the filtered key SHALL change only after the synchronized value differs from it for DEB_CYC consecutive cycles.
REQ-012 Press event SHALL be a 1-cycle pulse on the filtered key 1->0 edge only; holding or releasing the key produces no further event.
REQ-013 Modes: SHIFT=0, BOUNCE=1, BLINK=2, COUNT=3; each press advances mode by 1, wrapping 3->0.
REQ-014 On a press, in the same edge: mode advances, tick counter clears to 0, and led loads the entry pattern of the new mode.
REQ-015 Entry patterns: SHIFT 6'b111110; BOUNCE 6'b111110 with direction up; BLINK 6'b000000; COUNT binary count 0, led 6'b111111.
REQ-016 SHIFT: on each tick, led rotates left by one bit ({led[4:0],led[5]}).
REQ-017 BOUNCE: on each tick, the single lit bit moves one position in the current direction; direction flips up->down when bit 5 becomes lit and down->up when bit 0 becomes lit, with no repeat at the ends.
REQ-018 BLINK: on each tick, led inverts (all lit <-> all dark).
REQ-019 COUNT: on each tick, a 6-bit count increments and wraps 63->0; led = ~count.
REQ-020 led and mode SHALL update on the clock edge where tick or press is high, so they are visible one cycle later.
REQ-021 When press and tick occur in the same cycle, press SHALL win and that tick is discarded.
REQ-022 Between events, led and mode SHALL hold their values.

Reset
REQ-030 While sys_rst_n=0, regardless of clock: mode=SHIFT, led=6'b111110, tick counter=0, count=0, direction=up, synchronizer and filtered key=1 (released), debounce counter=0.
REQ-031 Reset asserted mid-sequence or mid-debounce SHALL abandon it; after release, operation resumes from the reset state with no spurious press.

Configuration
REQ-040 Macro LED_DEBOUNCE_EN: when defined, REQ-011 applies in full.
REQ-041 When LED_DEBOUNCE_EN is undefined, the filtered key SHALL equal the synchronized key (2-cycle latency) and DEB_CYC is ignored.

Structure
REQ-050 Package led_pkg SHALL hold the mode enum (SHIFT/BOUNCE/BLINK/COUNT), the entry-pattern constants and the LED width of 6.
REQ-051 Synchronizer and debounce SHALL live in sub-module key_debounce, which outputs the 1-cycle press pulse; the tick counter and pattern FSM stay in led_mode_ctrl.

Verification (TICK_CYC=4, DEB_CYC=3)
REQ-060 Reset release with key_n=1 -> led 111110, 111101, 111011, ... changing every 4 cycles, mode=0; after 6 ticks the pattern returns to 111110.
REQ-061 key_n low for 10 cycles -> exactly one mode change to BOUNCE, led=111110 next; lit bit walks 0..5 then back 4..0, with no duplicate state at the ends.
REQ-062 key_n glitch low for 2 cycles with LED_DEBOUNCE_EN defined -> no mode change; the same glitch without the macro -> mode advances.
REQ-063 Press timed so the press pulse coincides with a tick in BLINK -> mode=COUNT, led=111111, and the next change occurs 4 cycles later (led=111110).
REQ-064 In COUNT mode after 63 ticks, led=000000; the next tick gives led=111111 (wrap); four presses from any mode return to the same mode.
REQ-065 sys_rst_n pulsed low asynchronously mid-debounce in BOUNCE -> outputs immediately return to 111110/mode 0; with key_n still low after release, no press occurs until key_n releases and is pressed again.
